mfm_write_encoder: RTL and testbench

Write-side counterpart of the MFM clock-recovery PLL. Accepts bytes through a valid/ready handshake, MFM-encodes them MSB first, and drives write pulses and a write gate to the drive at 5 Mbit/s, one 200 ns bit cell = two 100 ns half-cells. It sits between the controller's sector formatter and the drive write interface. It supports address marks with a missing clock and sticky underrun reporting.

---
 rtl/mfm_write_encoder.sv | 224 ++++++++++++++++++++++
 tb/tb_mfm_write_encoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_write_encoder.sv
// MFM write encoder: bytes in over valid/ready, MSB-first MFM pulses and write gate out.
// Define MFM_WRITE_PRECOMP_EN to add a 4-half-cell look-ahead stage with write precompensation.
module mfm_write_encoder #(
  parameter int HALF_CELL = 5,
  parameter int PULSE_W   = 2,
  parameter int PRECOMP   = 1
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       mark_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       write_gate,
  output logic       mfm_out,
  output logic       underrun,
  output logic       busy
);

  localparam int CW = $clog2(HALF_CELL + 1);
  // a late-shifted pulse must still end inside its own half-cell
  localparam int PULSE_LEN = (PULSE_W + 2 * PRECOMP <= HALF_CELL) ? PULSE_W : HALF_CELL - 2 * PRECOMP;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CELL - 1);
  localparam logic [CW-1:0] PW       = CW'(PULSE_LEN);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    hold_q, hold_d;
  logic [8:0]    shift_q, shift_d;
  logic          hold_empty_q, hold_empty_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;
  logic          underrun_q, underrun_d;
  logic          write_gate_q, write_gate_d;
  logic          mfm_q, mfm_d;
  logic          busy_q, busy_d;
  logic          last_s, drain_s, active_s, pulse_s, accept_s;

  // Pulse for half-cell idx of byte sh ({mark, data}); even idx = clock, odd idx = data.
  function automatic logic hc_pulse(input logic [8:0] sh, input logic [3:0] idx, input logic prev);
    logic [2:0] bit_i;
    logic       b;
    logic       p;
    bit_i = 3'd7 - idx[3:1];
    b     = sh[bit_i];
    p     = (bit_i == 3'd7) ? prev : sh[bit_i + 3'd1];
    if (idx[0]) begin
      hc_pulse = b;
    end else begin
      hc_pulse = !p && !b && !(sh[8] && (bit_i == 3'd2));
    end
  endfunction

  // Sequencer: holding/shift registers, half-cell timing and byte-boundary decisions
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    underrun_d   = underrun_q;
    last_s       = (cnt_q == CNT_LAST);
    accept_s     = data_valid && hold_empty_q;
    case (state_q)
      IDLE: begin
        underrun_d = 1'b0;
        if (wr_en && !hold_empty_q && !drain_s) begin
          state_d      = ACTIVE;
          shift_d      = hold_q;
          hold_empty_d = 1'b1;
          idx_d        = 4'd0;
          cnt_d        = {CW{1'b0}};
          prev_d       = 1'b0;
        end else if (drain_s) begin
          cnt_d = last_s ? {CW{1'b0}} : cnt_q + CW'(1);
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      ACTIVE: begin
        if (!last_s) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = {CW{1'b0}};
          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
          end else begin
            idx_d  = 4'd0;
            prev_d = shift_q[0];
            if (!wr_en) begin
              state_d      = IDLE;
              hold_empty_d = 1'b1;
              underrun_d   = 1'b0;
            end else if (!hold_empty_q) begin
              shift_d      = hold_q;
              hold_empty_d = 1'b1;
            end else begin
              shift_d    = 9'h000;
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // a new byte can land in holding while the old one moves to shift
    if (accept_s) begin
      hold_d       = {mark_in, data_in};
      hold_empty_d = 1'b0;
    end else begin
      hold_d = hold_d;
    end
  end

  // Encoded pulse for the half-cell that the next cycle belongs to
  always_comb begin
    active_s = (state_d == ACTIVE);
    pulse_s  = active_s && hc_pulse(shift_d, idx_d, prev_d);
    busy_d   = active_s;
  end

`ifdef MFM_WRITE_PRECOMP_EN
  logic [7:0]    pp_q, pp_d;
  logic [4:0]    pg_q, pg_d;
  logic [2:0]    dn_s, dp_s;
  logic [CW-1:0] off_s;
  logic          start_s, enter_s;

  assign drain_s = |pg_q;

  // History window: pp[4] is the half-cell on the wire, pp[3:0] look-ahead, pp[7:5] look-back
  always_comb begin
    enter_s = (state_q == IDLE) && active_s;
    start_s = enter_s || ((state_q == ACTIVE) && last_s) || ((state_q == IDLE) && drain_s && last_s);
    if (start_s) begin
      pp_d = {(enter_s ? 7'd0 : pp_q[6:0]), pulse_s};
      pg_d = {pg_q[3:0], active_s};
    end else begin
      pp_d = pp_q;
      pg_d = pg_q;
    end
  end

  // Shift late when the previous pulse is closer, early when the next one is closer
  always_comb begin
    dn_s = pp_d[2] ? 3'd2 : (pp_d[1] ? 3'd3 : 3'd4);
    dp_s = pp_d[6] ? 3'd2 : (pp_d[7] ? 3'd3 : 3'd4);
    if (dp_s < dn_s) begin
      off_s = CW'(2 * PRECOMP);
    end else if (dn_s < dp_s) begin
      off_s = {CW{1'b0}};
    end else begin
      off_s = CW'(PRECOMP);
    end
    write_gate_d = pg_d[4];
    mfm_d        = pp_d[4] && (cnt_d >= off_s) && (cnt_d < off_s + PW);
  end

  // Precompensation pipeline registers
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      pp_q <= 8'd0;
      pg_q <= 5'd0;
    end else begin
      pp_q <= pp_d;
      pg_q <= pg_d;
    end
  end
`else
  assign drain_s = 1'b0;

  // Direct drive: pulse at offset 0 of its half-cell
  always_comb begin
    write_gate_d = active_s;
    mfm_d        = pulse_s && (cnt_d < PW);
  end
`endif

  // Main registers; reset clears everything and drops the drive outputs at once
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= 9'h000;
      hold_empty_q <= 1'b1;
      shift_q      <= 9'h000;
      idx_q        <= 4'd0;
      cnt_q        <= {CW{1'b0}};
      prev_q       <= 1'b0;
      underrun_q   <= 1'b0;
      write_gate_q <= 1'b0;
      mfm_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      underrun_q   <= underrun_d;
      write_gate_q <= write_gate_d;
      mfm_q        <= mfm_d;
      busy_q       <= busy_d;
    end
  end

  assign data_ready = hold_empty_q;
  assign write_gate = write_gate_q;
  assign mfm_out    = mfm_q;
  assign underrun   = underrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Directed bench for mfm_write_encoder: half-cell patterns, marks, underrun, wr_en drop, reset.
// Expectations follow the default build; MFM_WRITE_PRECOMP_EN selects the precomp variants.
module tb_mfm_write_encoder;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       mark_in = 1'b0;
  logic       data_valid = 1'b0;
  logic       data_ready, write_gate, mfm_out, underrun, busy;

  int n_tests = 0;
  int n_fail = 0;

`ifdef MFM_WRITE_PRECOMP_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 2;
`endif

  logic [15:0] words [0:3];
  int          offs [0:63];
  int          wids [0:63];
  int          gate_err;
  int          wait_cyc;

  mfm_write_encoder dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .mark_in   (mark_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .write_gate(write_gate),
    .mfm_out   (mfm_out),
    .underrun  (underrun),
    .busy      (busy)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic m);
    int t;
    t = 0;
    data_in    = d;
    mark_in    = m;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && t < 400) begin
      tick(1);
      t++;
    end
    chk("send_ready", 32'(t < 400), 32'd1);
    tick(1);
    data_valid = 1'b0;
    mark_in    = 1'b0;
    chk("ready_fall", 32'(data_ready), 32'd0);
  endtask

  // Waits for write_gate, then samples every cycle of nbytes bytes, recording half-cell pulses.
  task automatic capture(input int nbytes);
    int h;
    int c;
    wait_cyc = 0;
    gate_err = 0;
    while (write_gate !== 1'b1 && wait_cyc < 400) begin
      tick(1);
      wait_cyc++;
    end
    for (int i = 0; i < 4; i++) words[i] = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      offs[i] = -1;
      wids[i] = 0;
    end
    for (int k = 0; k < nbytes * 80; k++) begin
      if (k > 0) tick(1);
      h = k / 5;
      c = k % 5;
      if (write_gate !== 1'b1) gate_err++;
      if (mfm_out === 1'b1) begin
        if (offs[h] < 0) offs[h] = c;
        wids[h]++;
        words[h / 16][15 - (h % 16)] = 1'b1;
      end
    end
  endtask

  task automatic check_shape(input string tag, input int nh);
    int bad;
    bad = 0;
    for (int h = 0; h < nh; h++) begin
      if (wids[h] != 0) begin
        if (wids[h] != 2) bad++;
`ifndef MFM_WRITE_PRECOMP_EN
        if (offs[h] != 0) bad++;
`endif
      end
    end
    chk(tag, 32'(bad), 32'd0);
    chk({tag, "_gate"}, 32'(gate_err), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_gate"}, 32'(write_gate), 32'd0);
    chk({tag, "_ready"}, 32'(data_ready), 32'd1);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    int t;
    int bad;
    int eo;

    tick(3);
    chk("rst_ready", 32'(data_ready), 32'd1);
    chk("rst_gate", 32'(write_gate), 32'd0);
    chk("rst_mfm", 32'(mfm_out), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick(2);

    // 0x00 then 0xFF, wr_en dropped in the middle of the second byte
    wr_en = 1'b1;
    fork
      begin
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        tick(119);
        wr_en = 1'b0;
      end
      capture(2);
    join
    chk("t1_latency", 32'(wait_cyc), 32'(LAT));
    chk("t1_byte00", 32'(words[0]), 32'h0000AAAA);
    chk("t1_byteFF", 32'(words[1]), 32'h00005555);
    check_shape("t1_shape", 32);
    tick(1);
    chk("t1_gate_fall", 32'(write_gate), 32'd0);
`ifdef MFM_WRITE_PRECOMP_EN
    bad = 0;
    for (int h = 0; h < 32; h++) begin
      if (wids[h] != 0) begin
        eo = (h == 0 || h == 17) ? 0 : ((h == 14 || h == 31) ? 2 : 1);
        if (offs[h] != eo) bad++;
      end
    end
    chk("t1_precomp_offsets", 32'(bad), 32'd0);
`endif
    tick(30);
    check_idle("t1_idle");

    // Preamble 0x00, marked 0xA1, unmarked 0xA1
    wr_en = 1'b1;
    fork
      begin
        send(8'h00, 1'b0);
        send(8'hA1, 1'b1);
        send(8'hA1, 1'b0);
        tick(119);
        wr_en = 1'b0;
      end
      capture(3);
    join
    chk("t2_latency", 32'(wait_cyc), 32'(LAT));
    chk("t2_pre", 32'(words[0]), 32'h0000AAAA);
    chk("t2_mark", 32'(words[1]), 32'h00004489);
    chk("t2_nomark", 32'(words[2]), 32'h000044A9);
    check_shape("t2_shape", 48);
    tick(1);
    chk("t2_gate_fall", 32'(write_gate), 32'd0);
    tick(30);
    check_idle("t2_idle");

    // Single byte 0x4E, then starve the encoder
    wr_en = 1'b1;
    fork
      begin
        send(8'h4E, 1'b0);
        tick(80);
        chk("t3_underrun_pre", 32'(underrun), 32'd0);
        tick(1);
        chk("t3_underrun_set", 32'(underrun), 32'd1);
        tick(39);
        wr_en = 1'b0;
        tick(40);
        chk("t3_underrun_hold", 32'(underrun), 32'd1);
        tick(1);
        chk("t3_underrun_clr", 32'(underrun), 32'd0);
        chk("t3_busy_clr", 32'(busy), 32'd0);
      end
      capture(2);
    join
    chk("t3_byte4E", 32'(words[0]), 32'h00009254);
    chk("t3_fill00", 32'(words[1]), 32'h0000AAAA);
    check_shape("t3_shape", 32);
    tick(30);
    check_idle("t3_idle");

    // wr_en drops at half-cell 5 while 0xFF waits in holding
    wr_en = 1'b1;
    fork
      begin
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        tick(24);
        wr_en = 1'b0;
        tick(54);
        chk("t4_held", 32'(data_ready), 32'd0);
        tick(1);
        chk("t4_flushed", 32'(data_ready), 32'd1);
        chk("t4_busy_clr", 32'(busy), 32'd0);
      end
      capture(1);
    join
    chk("t4_byte00", 32'(words[0]), 32'h0000AAAA);
    check_shape("t4_shape", 16);
    tick(1);
    chk("t4_gate_fall", 32'(write_gate), 32'd0);
    wr_en = 1'b1;
    tick(30);
    chk("t4_discarded", 32'(busy), 32'd0);
    wr_en = 1'b0;
    tick(2);

    // Reset asserted mid-pulse with underrun set
    wr_en = 1'b1;
    send(8'h00, 1'b0);
    t = 0;
    while (underrun !== 1'b1 && t < 300) begin
      tick(1);
      t++;
    end
    chk("t5_underrun_seen", 32'(underrun), 32'd1);
    t = 0;
    while (mfm_out !== 1'b1 && t < 100) begin
      tick(1);
      t++;
    end
    chk("t5_pulse_seen", 32'(mfm_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_mfm", 32'(mfm_out), 32'd0);
    chk("t5_gate", 32'(write_gate), 32'd0);
    chk("t5_ready", 32'(data_ready), 32'd1);
    chk("t5_underrun", 32'(underrun), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    #5;
    reset = 1'b1;
    tick(10);
    chk("t5_stay_idle", 32'(busy), 32'd0);
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
